rr_priority_encoder: RTL and testbench

Registered, handshaked successor to the combinational `priority_encoder`. Request bits are latched into a sticky pending vector, and one index is granted at a time on `out` with `valid`. The grant holds until the consumer returns `ack`, and the serviced bit is then cleared. Selection is either fixed priority (highest index wins) or round robin, chosen per cycle by `rr_en`. The block sits between interrupt/event sources and a single serialising consumer.

---
 rtl/rr_priority_encoder.sv | 91 +++++++++
 tb/tb_rr_priority_encoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rr_priority_encoder.sv
// Registered, handshaked priority encoder: sticky pending requests, one grant
// at a time held until ack, fixed-priority or round-robin selection per cycle.
module rr_priority_encoder #(
   parameter int m = 8,
   parameter int n = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [m-1:0] in,
   input  logic         rr_en,
   input  logic         ack,
   output logic [n-1:0] out,
   output logic         valid,
   output logic [m-1:0] pending
);

   typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

   localparam logic [n-1:0] LAST = n'(m - 1);

   state_t         r_state, w_state_n;
   logic [n-1:0]   r_out, w_out_n;
   logic [n-1:0]   r_ptr, w_ptr_n;
   logic [m-1:0]   r_pending, w_pend_n;
   logic [m-1:0]   w_clr;
   logic           w_fire;
   logic [2*m-1:0] w_rot;
   logic [n:0]     w_sum;
   logic [n-1:0]   w_sel;
   logic           w_found;

   assign w_fire   = (r_state == GRANT) && ack;
   assign w_clr    = w_fire ? ({{(m-1){1'b0}}, 1'b1} << r_out) : '0;
   assign w_pend_n = (r_pending & ~w_clr) | in;
   assign w_ptr_n  = w_fire ? ((r_out == LAST) ? '0 : r_out + 1'b1) : r_ptr;
   // Doubling the vector turns the wrapping scan into a plain low-to-high scan.
   assign w_rot    = {w_pend_n, w_pend_n} >> w_ptr_n;

   always_comb begin
      w_sel   = '0;
      w_found = 1'b0;
      w_sum   = '0;
      if (rr_en) begin
         for (int k = 0; k < m; k++) begin
            if (!w_found && w_rot[k]) begin
               w_found = 1'b1;
               w_sum   = {1'b0, w_ptr_n} + (n+1)'(k);
               if (w_sum >= (n+1)'(m)) w_sum = w_sum - (n+1)'(m);
               w_sel   = w_sum[n-1:0];
            end
         end
      end else begin
         for (int i = 0; i < m; i++) begin
            if (w_pend_n[i]) w_sel = n'(i);
         end
      end
   end

   // A held grant is never preempted; a new selection only happens from IDLE or on fire.
   always_comb begin
      w_state_n = r_state;
      w_out_n   = r_out;
      if (r_state == IDLE || w_fire) begin
         if (|w_pend_n) begin
            w_state_n = GRANT;
            w_out_n   = w_sel;
         end else begin
            w_state_n = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_out     <= '0;
         r_ptr     <= '0;
         r_pending <= '0;
      end else begin
         r_state   <= w_state_n;
         r_out     <= w_out_n;
         r_ptr     <= w_ptr_n;
         r_pending <= w_pend_n;
      end
   end

   assign out     = r_out;
   assign valid   = (r_state == GRANT);
   assign pending = r_pending;

endmodule

// File: tb/tb_rr_priority_encoder.sv
// Directed and randomized bench for rr_priority_encoder against a queue-free
// behavioural model of the grant/ack protocol.
module tb_rr_priority_encoder;
   localparam int M = 8;
   localparam int N = 3;

   logic         clk = 1'b0;
   logic         rst;
   logic [M-1:0] in;
   logic         rr_en;
   logic         ack;
   logic [N-1:0] out;
   logic         valid;
   logic [M-1:0] pending;

   int checks   = 0;
   int failures = 0;

   // reference state
   bit         m_pend [M];
   int         m_out;
   bit         m_valid;
   int         m_ptr;

   rr_priority_encoder #(.m(M), .n(N)) dut (
      .clk(clk), .rst(rst), .in(in), .rr_en(rr_en), .ack(ack),
      .out(out), .valid(valid), .pending(pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_pend_vec();
      logic [31:0] v = 0;
      for (int i = 0; i < M; i++) if (m_pend[i]) v += (32'd1 << i);
      return v;
   endfunction

   task automatic model_step(input bit r, input logic [M-1:0] vin, input bit rr, input bit a);
      bit fire;
      bit any;
      int sel;
      if (r) begin
         for (int i = 0; i < M; i++) m_pend[i] = 0;
         m_out = 0; m_valid = 0; m_ptr = 0;
         return;
      end
      fire = m_valid && a;
      if (fire) begin
         m_pend[m_out] = 0;
         m_ptr = (m_out + 1) % M;
      end
      for (int i = 0; i < M; i++) if (vin[i]) m_pend[i] = 1;
      if (!m_valid || fire) begin
         any = 0; sel = 0;
         if (rr) begin
            for (int k = 0; k < M && !any; k++)
               if (m_pend[(m_ptr + k) % M]) begin any = 1; sel = (m_ptr + k) % M; end
         end else begin
            for (int i = M - 1; i >= 0 && !any; i--)
               if (m_pend[i]) begin any = 1; sel = i; end
         end
         m_valid = any;
         if (any) m_out = sel;
      end
   endtask

   // one clock: drive, advance model at the edge, compare just after it
   task automatic cyc(input bit r, input logic [M-1:0] vin, input bit rr, input bit a);
      rst = r; in = vin; rr_en = rr; ack = a;
      @(posedge clk);
      model_step(r, vin, rr, a);
      #1;
      chk("model_valid",   32'(valid),   32'(m_valid));
      chk("model_out",     32'(out),     32'(m_out));
      chk("model_pending", 32'(pending), model_pend_vec());
   endtask

   initial begin
      for (int i = 0; i < M; i++) m_pend[i] = 0;
      m_out = 0; m_valid = 0; m_ptr = 0;
      rst = 1; in = '0; rr_en = 0; ack = 0;

      // reset overrides in/ack
      cyc(1, 8'hFF, 0, 1);
      cyc(1, 8'hFF, 0, 1);
      chk("rst_valid", 32'(valid), 0);
      chk("rst_out", 32'(out), 0);
      chk("rst_pending", 32'(pending), 0);
      cyc(0, 8'h00, 0, 0);
      cyc(0, 8'h00, 0, 0);
      chk("post_rst_idle", {out, valid, pending}, 0);

      // walking one
      for (int i = 0; i < M; i++) begin
         cyc(0, 8'(1 << i), 0, 0);
         chk("walk_out", 32'(out), 32'(i));
         chk("walk_valid", 32'(valid), 1);
         cyc(0, 8'h00, 0, 1);
         chk("walk_pend_clear", 32'(pending), 0);
         chk("walk_valid_drop", 32'(valid), 0);
      end

      // fixed priority drain
      cyc(1, 8'h00, 0, 0);
      cyc(0, 8'b00001101, 0, 1);
      chk("fp_first", 32'(out), 3);
      cyc(0, 8'h00, 0, 1);
      chk("fp_second", 32'(out), 2);
      cyc(0, 8'h00, 0, 1);
      chk("fp_third", 32'(out), 0);
      chk("fp_third_valid", 32'(valid), 1);
      cyc(0, 8'h00, 0, 1);
      chk("fp_done", 32'(valid), 0);

      // hold without preemption
      cyc(1, 8'h00, 0, 0);
      cyc(0, 8'h01, 0, 0);
      chk("hold_grant", 32'(out), 0);
      cyc(0, 8'h80, 0, 0);
      chk("hold_no_preempt", 32'(out), 0);
      cyc(0, 8'h00, 0, 0);
      chk("hold_still", 32'(out), 0);
      cyc(0, 8'h00, 0, 1);
      chk("hold_next", 32'(out), 7);
      chk("hold_next_valid", 32'(valid), 1);

      // round robin with sustained ack
      cyc(1, 8'h00, 1, 0);
      for (int r = 0; r < 2; r++) begin
         cyc(0, 8'b10000011, 1, 1);
         chk("rr_0", 32'(out), 0);
         cyc(0, 8'b10000011, 1, 1);
         chk("rr_1", 32'(out), 1);
         cyc(0, 8'b10000011, 1, 1);
         chk("rr_7", 32'(out), 7);
      end

      // set wins over clear in the ack cycle
      cyc(1, 8'h00, 0, 0);
      cyc(0, 8'h04, 0, 0);
      chk("sw_grant", 32'(out), 2);
      cyc(0, 8'h04, 0, 1);
      chk("sw_pending", 32'(pending[2]), 1);
      chk("sw_out", 32'(out), 2);
      chk("sw_valid", 32'(valid), 1);

      // randomized traffic
      for (int t = 0; t < 600; t++) begin
         logic [M-1:0] rin;
         rin = ($urandom_range(0, 3) == 0) ? 8'($urandom) : '0;
         cyc(($urandom_range(0, 99) == 0), rin, 1'($urandom), ($urandom_range(0, 2) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
